// File: rtl/color_conv_package.sv
// Shared types, constants and word-count helper for the colour-conversion
// control stage.
package color_conv_package;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } ctrl_state_e;

   // Single-line, single-feature transfers: the feature/loop machinery stays off.
   localparam logic [15:0] FEAT_LENGTH_DEF  = 16'd1;
   localparam logic [15:0] FEAT_STRIDE_DEF  = 16'd0;
   localparam logic [15:0] FEAT_ROLL_DEF    = 16'd0;
   localparam logic        LOOP_OUTER_DEF   = 1'b0;
   localparam logic        REALIGN_TYPE_DEF = 1'b0;

   // Written as quotient plus remainder test so it cannot overflow near all-ones.
   function automatic logic [63:0] ceil_div(input logic [63:0] num, input logic [63:0] den);
      return (num / den) + (((num % den) != 64'd0) ? 64'd1 : 64'd0);
   endfunction

endpackage

// File: rtl/hwpe_stream_package.sv
// Streamer-side control/flag structs for the source and sink ports that the
// colour-conversion control stage drives and observes.
package hwpe_stream_package;

   typedef struct packed {
      logic [31:0] base_addr;
      logic [31:0] trans_size;
      logic [15:0] line_stride;
      logic [15:0] line_length;
      logic [15:0] feat_stride;
      logic [15:0] feat_length;
      logic [15:0] feat_roll;
      logic        loop_outer;
      logic        realign_type;
      logic [7:0]  step;
   } ctrl_addressgen_t;

   typedef struct packed {
      logic             req_start;
      ctrl_addressgen_t addressgen_ctrl;
   } ctrl_sourcesink_t;

   typedef struct packed {
      logic ready_start;
      logic done;
   } flags_sourcesink_t;

endpackage

// File: rtl/color_conv_addrgen_cfg.sv
// Combinational builder of one streamer control struct from base address,
// word count and byte step; req_start is always left low here.
module color_conv_addrgen_cfg
   import hwpe_stream_package::*;
   import color_conv_package::*;
(
   input  logic [31:0]      base_addr,
   input  logic [31:0]      words,
   input  logic [7:0]       step,
   output ctrl_sourcesink_t ctrl
);

   always_comb begin
      ctrl = '0;
      ctrl.addressgen_ctrl.base_addr    = base_addr;
      ctrl.addressgen_ctrl.trans_size   = words;
      ctrl.addressgen_ctrl.line_length  = words[15:0];
      ctrl.addressgen_ctrl.line_stride  = {8'd0, step};
      ctrl.addressgen_ctrl.feat_length  = FEAT_LENGTH_DEF;
      ctrl.addressgen_ctrl.feat_stride  = FEAT_STRIDE_DEF;
      ctrl.addressgen_ctrl.feat_roll    = FEAT_ROLL_DEF;
      ctrl.addressgen_ctrl.loop_outer   = LOOP_OUTER_DEF;
      ctrl.addressgen_ctrl.realign_type = REALIGN_TYPE_DEF;
      ctrl.addressgen_ctrl.step         = step;
   end

endmodule

// File: rtl/color_conv_ctrl_fsm.sv
// Job control for the colour-conversion streamer: latches a job, handshakes
// start with source and sink, waits for both done flags and times the job.
module color_conv_ctrl_fsm
   import hwpe_stream_package::*;
   import color_conv_package::*;
#(
   parameter int unsigned STREAM_WIDTH = 96,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [31:0]          src_addr_i,
   input  logic [31:0]          dst_addr_i,
   input  logic [CNT_WIDTH-1:0] n_pixels_i,
   output ctrl_sourcesink_t     source_stream_ctrl_o,
   input  flags_sourcesink_t    source_stream_flags_i,
   output ctrl_sourcesink_t     sink_stream_ctrl_o,
   input  flags_sourcesink_t    sink_stream_flags_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_WIDTH-1:0] cycles_o
);

   localparam int unsigned PIX_PER_WORD = STREAM_WIDTH / 24;
   localparam int unsigned STEP         = STREAM_WIDTH / 8;
   localparam logic [7:0]  STEP_B       = 8'(STEP);

   ctrl_state_e          state_reg, state_next;
   logic [CNT_WIDTH-1:0] words_in;
   logic [31:0]          words_32;
   logic [31:0]          base_in  [2];
   ctrl_sourcesink_t     cfg      [2];
   ctrl_sourcesink_t     ctrl_reg [2];
   ctrl_sourcesink_t     ctrl_out [2];
   logic                 src_done_reg, snk_done_reg;
   logic [CNT_WIDTH-1:0] cnt_reg, cycles_reg;
   logic                 job_start, handshake, both_done, req_start;

   assign words_in   = CNT_WIDTH'(ceil_div(64'(n_pixels_i), 64'(PIX_PER_WORD)));
   assign words_32   = 32'(words_in);
   assign base_in[0] = src_addr_i;
   assign base_in[1] = dst_addr_i;

   assign job_start = (state_reg == IDLE) && start_i && !clear_i;
   assign handshake = (state_reg == START) && source_stream_flags_i.ready_start
                      && sink_stream_flags_i.ready_start && !clear_i;
   assign both_done = (src_done_reg | source_stream_flags_i.done)
                      & (snk_done_reg | sink_stream_flags_i.done);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_i) state_next = (words_in == '0) ? FINISH : START;
         START:   if (handshake) state_next = RUN;
         RUN:     if (both_done) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (clear_i) state_next = IDLE;
   end

   always_comb begin
      req_start = handshake;
      busy_o    = (state_reg != IDLE);
      done_o    = (state_reg == FINISH) && !clear_i;
   end

   // Address fields survive clear; only reset or a new job start touches them.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         color_conv_addrgen_cfg u_cfg (
            .base_addr (base_in[gi]),
            .words     (words_32),
            .step      (STEP_B),
            .ctrl      (cfg[gi])
         );

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)        ctrl_reg[gi] <= '0;
            else if (job_start) ctrl_reg[gi] <= cfg[gi];
         end

         always_comb begin
            ctrl_out[gi]           = ctrl_reg[gi];
            ctrl_out[gi].req_start = ctrl_reg[gi].req_start | req_start;
         end
      end
   endgenerate

   assign source_stream_ctrl_o = ctrl_out[0];
   assign sink_stream_ctrl_o   = ctrl_out[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_done_reg <= 1'b0;
         snk_done_reg <= 1'b0;
      end else if (clear_i || state_reg == FINISH) begin
         src_done_reg <= 1'b0;
         snk_done_reg <= 1'b0;
      end else if (state_reg == RUN) begin
         if (source_stream_flags_i.done) src_done_reg <= 1'b1;
         if (sink_stream_flags_i.done)   snk_done_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg    <= '0;
         cycles_reg <= '0;
      end else begin
         if (clear_i || job_start)
            cnt_reg <= '0;
         else if (state_reg != IDLE && cnt_reg != '1)
            cnt_reg <= cnt_reg + 1'b1;
         if (state_reg == FINISH && !clear_i)
            cycles_reg <= cnt_reg;
      end
   end

   assign cycles_o = cycles_reg;

endmodule
